// File: rtl/datapath_arbiter_pkg.sv
// rtl/datapath_arbiter_pkg.sv - shared widths and FSM encodings for the datapath arbiter
package datapath_arbiter_pkg;

    localparam int INSTRUCTION_WIDTH = 16;
    localparam int RESULT_WIDTH      = 8;
    localparam int ARB_OP_WIDTH      = 3;

    typedef enum logic [ARB_OP_WIDTH-1:0] {
        ARB_OP_IDLE       = 3'd0,
        ARB_OP_ISSUE      = 3'd1,
        ARB_OP_ISSUE_HOLD = 3'd2,
        ARB_OP_WAIT       = 3'd3,
        ARB_OP_DONE       = 3'd4
    } arb_state_t;

endpackage

// File: rtl/datapath_arbiter_if.sv
// rtl/datapath_arbiter_if.sv - client-side and datapath-side handshake bundle of the arbiter
interface datapath_arbiter_if
    import datapath_arbiter_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int INSTR_W     = INSTRUCTION_WIDTH,
    parameter int RES_W       = RESULT_WIDTH,
    parameter int ID_W        = 3
);
    logic [NUM_CLIENTS-1:0]         c_start;
    logic [NUM_CLIENTS*INSTR_W-1:0] c_instruction;
    logic [NUM_CLIENTS-1:0]         c_finished;
    logic [RES_W-1:0]               c_result;
    logic                           start_dp;
    logic [INSTR_W-1:0]             instruction_dp;
    logic                           finished_dp;
    logic [RES_W-1:0]               result_dp;
    logic                           busy;
    logic [ID_W-1:0]                grant_id;

    // arbiter view
    modport master (
        input  c_start, c_instruction, finished_dp, result_dp,
        output c_finished, c_result, start_dp, instruction_dp, busy, grant_id
    );

    // clients plus datapath view
    modport slave (
        output c_start, c_instruction, finished_dp, result_dp,
        input  c_finished, c_result, start_dp, instruction_dp, busy, grant_id
    );
endinterface

// File: rtl/datapath_arbiter_rr_picker.sv
// rtl/datapath_arbiter_rr_picker.sv - round-robin pick of the first pending client at or after rr_ptr
module datapath_arbiter_rr_picker #(
    parameter int N   = 4,
    parameter int IDW = 3
) (
    input  logic [N-1:0]   i_pending,
    input  logic [IDW-1:0] i_rr_ptr,
    output logic [IDW-1:0] o_grant,
    output logic           o_any_valid
);
    localparam logic [IDW:0] L_N = (IDW+1)'(N);

    logic [2*N-1:0] w_dbl;
    logic [IDW:0]   w_sel;
    logic           w_found;

    assign w_dbl = {i_pending, i_pending};

    // lowest set bit of the doubled vector at or above rr_ptr covers the wrap-around
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        for (int k = 2*N-1; k >= 0; k--) begin
            if (w_dbl[k] && (k >= int'(i_rr_ptr))) begin
                w_sel   = k[IDW:0];
                w_found = 1'b1;
            end
        end
    end

    assign o_grant     = (w_sel >= L_N) ? IDW'(w_sel - L_N) : IDW'(w_sel);
    assign o_any_valid = w_found;

endmodule

// File: rtl/datapath_arbiter.sv
// rtl/datapath_arbiter.sv - shares one datapath between NUM_CLIENTS requesters, round-robin
module datapath_arbiter
    import datapath_arbiter_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int INSTR_W     = INSTRUCTION_WIDTH,
    parameter int RES_W       = RESULT_WIDTH,
    parameter int ID_W        = 3
) (
    input  logic         clock,
    input  logic         resetn,
    datapath_arbiter_if.master bus
);
    localparam int              IW     = $clog2(NUM_CLIENTS);
    localparam logic [ID_W-1:0] L_LAST = ID_W'(NUM_CLIENTS - 1);

    arb_state_t               r_state;
    arb_state_t               w_next_state;
    logic [NUM_CLIENTS-1:0]   r_pending;
    logic [NUM_CLIENTS-1:0]   r_finished;
    logic [INSTR_W-1:0]       r_inst_q [NUM_CLIENTS];
    logic [RES_W-1:0]         r_result;
    logic                     r_start;
    logic [INSTR_W-1:0]       r_instr;
    logic [ID_W-1:0]          r_grant;
    logic                     r_busy;
    logic [ID_W-1:0]          r_rr_ptr;

    logic [NUM_CLIENTS-1:0]   w_capture;
    logic [ID_W-1:0]          w_pick;
    logic                     w_any;
    logic                     w_load;
    logic                     w_complete;
    logic                     w_end_start;
    logic                     w_done;
    logic [ID_W-1:0]          w_next_ptr;

    datapath_arbiter_rr_picker #(
        .N   (NUM_CLIENTS),
        .IDW (ID_W)
    ) u_rr_picker (
        .i_pending   (r_pending),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_pick),
        .o_any_valid (w_any)
    );

    // a start is taken only from a client that is neither queued nor being served
    always_comb begin
        w_capture = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            w_capture[i] = bus.c_start[i] && !r_pending[i] &&
                           !(r_busy && (r_grant == i[ID_W-1:0]));
        end
    end

    assign w_next_ptr = (r_grant == L_LAST) ? '0 : r_grant + ID_W'(1);

    // state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= ARB_OP_IDLE;
        else         r_state <= w_next_state;
    end

    // next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_OP_IDLE:       if (w_any) w_next_state = ARB_OP_ISSUE;
            ARB_OP_ISSUE:      w_next_state = ARB_OP_ISSUE_HOLD;
            ARB_OP_ISSUE_HOLD: w_next_state = ARB_OP_WAIT;
            ARB_OP_WAIT:       if (bus.finished_dp) w_next_state = ARB_OP_DONE;
            ARB_OP_DONE:       w_next_state = ARB_OP_IDLE;
            default:           w_next_state = ARB_OP_IDLE;
        endcase
    end

    // per-state control strobes
    always_comb begin
        w_load      = (r_state == ARB_OP_IDLE) && w_any;
        w_end_start = (r_state == ARB_OP_ISSUE_HOLD);
        w_complete  = (r_state == ARB_OP_WAIT) && bus.finished_dp;
        w_done      = (r_state == ARB_OP_DONE);
    end

    // per-client queue slot and finished flag
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pending  <= '0;
            r_finished <= '1;
            for (int i = 0; i < NUM_CLIENTS; i++) r_inst_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                if (w_capture[i]) begin
                    r_pending[i]  <= 1'b1;
                    r_inst_q[i]   <= bus.c_instruction[i*INSTR_W +: INSTR_W];
                    r_finished[i] <= 1'b0;
                end else if (w_complete && (r_grant == i[ID_W-1:0])) begin
                    r_pending[i]  <= 1'b0;
                    r_finished[i] <= 1'b1;
                end
            end
        end
    end

    // datapath-facing registers, grant bookkeeping and shared result
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_start  <= 1'b0;
            r_instr  <= '0;
            r_grant  <= '0;
            r_busy   <= 1'b0;
            r_result <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (w_load) begin
                r_instr <= r_inst_q[w_pick[IW-1:0]];
                r_start <= 1'b1;
                r_grant <= w_pick;
                r_busy  <= 1'b1;
            end
            if (w_end_start) r_start <= 1'b0;
            if (w_complete) begin
                r_result <= bus.result_dp;
                r_rr_ptr <= w_next_ptr;
            end
            if (w_done) r_busy <= 1'b0;
        end
    end

    assign bus.c_finished     = r_finished;
    assign bus.c_result       = r_result;
    assign bus.start_dp       = r_start;
    assign bus.instruction_dp = r_instr;
    assign bus.busy           = r_busy;
    assign bus.grant_id       = r_grant;

endmodule

// File: tb/tb_datapath_arbiter.sv
// tb/tb_datapath_arbiter.sv - self-checking bench for datapath_arbiter
module tb_datapath_arbiter;
    localparam int N   = 4;
    localparam int IW  = 16;
    localparam int RW  = 8;
    localparam int IDW = 3;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    datapath_arbiter_if #(.NUM_CLIENTS(N), .INSTR_W(IW), .RES_W(RW), .ID_W(IDW)) bus ();

    datapath_arbiter #(.NUM_CLIENTS(N), .INSTR_W(IW), .RES_W(RW), .ID_W(IDW)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    // datapath model: finishes 5 cycles after start rises, result = instr[7:0] ^ 0xAE
    int          timer      = 0;
    logic        prev_start = 1'b0;
    int          run        = 0;
    int          dp_starts  = 0;
    logic [15:0] last_instr = '0;
    logic [15:0] log_instr[$];
    int          log_gid[$];

    always @(negedge clock) begin
        if (!resetn) begin
            timer           = 0;
            bus.finished_dp = 1'b0;
            bus.result_dp   = '0;
            prev_start      = 1'b0;
            run             = 0;
        end else begin
            bus.finished_dp = 1'b0;
            if (timer > 0) begin
                timer--;
                if (timer == 0) begin
                    bus.finished_dp = 1'b1;
                    bus.result_dp   = last_instr[7:0] ^ 8'hAE;
                end
            end
            if (bus.start_dp) begin
                if (!prev_start) begin
                    timer      = 5;
                    last_instr = bus.instruction_dp;
                    log_instr.push_back(bus.instruction_dp);
                    log_gid.push_back(int'(bus.grant_id));
                    dp_starts++;
                    run = 0;
                end
                run++;
            end else if (prev_start) begin
                check("start_len", run, 2);
            end
            prev_start = bus.start_dp;
        end
    end

    typedef struct {
        logic [3:0]       mask;
        logic [3:0][15:0] instr;
        int               n;
        logic [3:0][1:0]  order;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input vec_t v, input int id);
        logic [3:0]  prevf;
        logic [3:0]  rise;
        logic [15:0] li;
        int          lg;
        int          got;
        got = 0;
        log_instr.delete();
        log_gid.delete();
        for (int c = 0; c < N; c++) if (v.mask[c]) bus.c_instruction[c*IW +: IW] = v.instr[c];
        bus.c_start = v.mask;
        tick();
        tick();
        bus.c_start = '0;
        prevf = bus.c_finished;
        for (int t = 0; t < 400 && !(got == v.n && !bus.busy); t++) begin
            tick();
            rise  = bus.c_finished & ~prevf;
            prevf = bus.c_finished;
            for (int c = 0; c < N; c++) begin
                if (rise[c]) begin
                    if (got < v.n) begin
                        check($sformatf("v%0d_order%0d", id, got), c, v.order[got]);
                        check($sformatf("v%0d_result%0d", id, got), bus.c_result, v.instr[c][7:0] ^ 8'hAE);
                        if (log_instr.size() > 0) begin
                            li = log_instr.pop_front();
                            lg = log_gid.pop_front();
                            check($sformatf("v%0d_dp_instr%0d", id, got), li, v.instr[c]);
                            check($sformatf("v%0d_grant%0d", id, got), lg, c);
                        end else begin
                            check($sformatf("v%0d_dp_issued%0d", id, got), 0, 1);
                        end
                        for (int j = got + 1; j < v.n; j++)
                            check($sformatf("v%0d_later_low%0d", id, j), bus.c_finished[v.order[j]], 0);
                    end
                    got++;
                end
            end
        end
        check($sformatf("v%0d_count", id), got, v.n);
        check($sformatf("v%0d_fin_all", id), bus.c_finished, 4'hF);
    endtask

    initial begin
        int          comp;
        int          rises;
        int          hc [2];
        int          base;
        logic [3:0]  prevf;
        logic [3:0]  rise;
        logic        seen;

        bus.c_start       = '0;
        bus.c_instruction = '0;

        // record table: order is hand-derived from rr_ptr carried between records
        vecs[0].mask = 4'b1101; vecs[0].n = 3; vecs[0].order[0] = 2; vecs[0].order[1] = 3; vecs[0].order[2] = 0;
        vecs[1].mask = 4'b0010; vecs[1].n = 1; vecs[1].order[0] = 1;
        vecs[2].mask = 4'b1111; vecs[2].n = 4; vecs[2].order[0] = 2; vecs[2].order[1] = 3; vecs[2].order[2] = 0; vecs[2].order[3] = 1;
        vecs[3].mask = 4'b0011; vecs[3].n = 2; vecs[3].order[0] = 0; vecs[3].order[1] = 1;
        vecs[4].mask = 4'b1000; vecs[4].n = 1; vecs[4].order[0] = 3;
        vecs[5].mask = 4'b1010; vecs[5].n = 2; vecs[5].order[0] = 1; vecs[5].order[1] = 3;
        vecs[6].mask = 4'b0001; vecs[6].n = 1; vecs[6].order[0] = 0;
        for (int v = 0; v < 7; v++)
            for (int c = 0; c < N; c++)
                vecs[v].instr[c] = 16'((v + 1) * 4096 + c * 256 + v * 16 + c + 5);

        // reset state
        tick();
        tick();
        check("rst_finished", bus.c_finished, 4'hF);
        check("rst_start", bus.start_dp, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_grant", bus.grant_id, 0);
        check("rst_result", bus.c_result, 0);
        check("rst_instr", bus.instruction_dp, 0);
        resetn = 1'b1;
        tick();

        // single client 1, hand-timed
        bus.c_start[1] = 1'b1;
        bus.c_instruction[1*IW +: IW] = 16'h0ABC;
        tick();
        check("s_fin_low", bus.c_finished[1], 0);
        check("s_start_t1", bus.start_dp, 0);
        tick();
        bus.c_start[1] = 1'b0;
        check("s_start_t2", bus.start_dp, 1);
        check("s_instr", bus.instruction_dp, 16'h0ABC);
        check("s_grant", bus.grant_id, 1);
        check("s_busy", bus.busy, 1);
        tick();
        check("s_start_t3", bus.start_dp, 1);
        tick();
        check("s_start_t4", bus.start_dp, 0);
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            if (bus.finished_dp) seen = 1'b1;
            else tick();
        end
        check("s_dp_finished_seen", seen, 1);
        check("s_fin_still_low", bus.c_finished[1], 0);
        tick();
        check("s_fin_rise", bus.c_finished[1], 1);
        check("s_result", bus.c_result, 8'h12);
        check("s_one_start", dp_starts, 1);
        tick();
        tick();
        check("s_idle", bus.busy, 0);

        // table-driven vectors; rr_ptr is 2 after client 1
        for (int v = 0; v < 6; v++) run_vec(vecs[v], v);

        // fairness: clients 0 and 1 re-request after every completion; rr_ptr is 0 here
        comp  = 0;
        hc[0] = 2;
        hc[1] = 2;
        bus.c_instruction[0*IW +: IW] = 16'h5A10;
        bus.c_instruction[1*IW +: IW] = 16'h5A21;
        prevf = bus.c_finished;
        for (int t = 0; t < 3000 && comp < 21; t++) begin
            for (int c = 0; c < 2; c++) begin
                bus.c_start[c] = (hc[c] > 0);
                if (hc[c] > 0) hc[c]--;
            end
            tick();
            rise  = bus.c_finished & ~prevf;
            prevf = bus.c_finished;
            for (int c = 0; c < 2; c++) begin
                if (rise[c]) begin
                    check($sformatf("fair_%0d", comp), c, comp % 2);
                    comp++;
                    if (comp < 20) hc[c] = 2;
                end
            end
        end
        bus.c_start = '0;
        check("fair_count", comp, 21);
        tick();
        tick();

        // duplicate start: client 2 holds start 6 cycles; rr_ptr is 1 here
        base  = dp_starts;
        rises = 0;
        bus.c_instruction[2*IW +: IW] = 16'h3C77;
        prevf = bus.c_finished;
        for (int t = 0; t < 40; t++) begin
            bus.c_start[2] = (t < 6);
            tick();
            rise  = bus.c_finished & ~prevf;
            prevf = bus.c_finished;
            if (rise[2]) begin
                rises++;
                check("dup_result", bus.c_result, 8'h77 ^ 8'hAE);
            end
        end
        bus.c_start = '0;
        check("dup_one_txn", dp_starts - base, 1);
        check("dup_one_rise", rises, 1);

        // reset while client 3 is in WAIT
        bus.c_instruction[3*IW +: IW] = 16'h4D33;
        bus.c_start[3] = 1'b1;
        tick();
        tick();
        bus.c_start[3] = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            if (bus.busy && !bus.start_dp && bus.grant_id == 3) seen = 1'b1;
            else tick();
        end
        check("rw_reached_wait", seen, 1);
        tick();
        check("rw_fin3_low", bus.c_finished[3], 0);
        resetn = 1'b0;
        #1;
        check("rw_async_finished", bus.c_finished, 4'hF);
        check("rw_async_start", bus.start_dp, 0);
        check("rw_async_busy", bus.busy, 0);
        check("rw_async_grant", bus.grant_id, 0);
        tick();
        tick();
        resetn = 1'b1;
        base = dp_starts;
        for (int t = 0; t < 10; t++) tick();
        check("rw_pending_cleared", dp_starts - base, 0);
        run_vec(vecs[6], 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
